// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: BHT geometry, 2-bit counter
// encodings, the IF->EX tracking record and the saturating counter step.
package branch_resolve_unit_pkg;

  localparam int          DEF_BHT_IDX_W = 8;
  localparam logic [31:0] PC_INC        = 32'd4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } track_t;

  function automatic bht_cnt_e cnt_update(input bht_cnt_e cnt, input logic taken);
    if (taken) return (cnt == ST)  ? ST  : bht_cnt_e'(cnt + 2'd1);
    else       return (cnt == SNT) ? SNT : bht_cnt_e'(cnt - 2'd1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Branch history table of 2-bit saturating counters: combinational read port for
// IF, synchronous saturating update port for EX. No write-to-read bypass.
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int IDX_W = DEF_BHT_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  bht_cnt_e cnt_q [ENTRIES];

  assign rd_cnt = cnt_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= cnt_update(cnt_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Directional prediction in IF (BHT gating the BTB hit), a prediction tracking
// pipe to EX, and EX-stage resolution driving flush, BTB update and BHT training.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int BHT_IDX_W  = DEF_BHT_IDX_W,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_in,
  input  logic             if_valid,
  input  logic             btb_hit,
  input  logic [31:0]      btb_target,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_pc,
  output logic [31:0]      next_pc,
  output logic             pred_taken,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             br_update,
  output logic [31:0]      pc_ex,
  output logic [31:0]      target_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  logic [1:0] bht_rd_cnt;
  logic       bht_wr_en;
  track_t     track_p [PIPE_DEPTH];
  track_t     ex_trk;
  logic       checked;
  logic       mispredict;

  bht_2bit #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (pc_in[BHT_IDX_W+1:2]),
    .rd_cnt   (bht_rd_cnt),
    .wr_en    (bht_wr_en),
    .wr_idx   (ex_pc[BHT_IDX_W+1:2]),
    .wr_taken (ex_taken)
  );

  // IF: BHT direction gates the BTB hit
  assign pred_taken = if_valid & btb_hit & bht_rd_cnt[1];
  assign next_pc    = pred_taken ? btb_target : pc_in + PC_INC;

  // tracking pipe: flush wins over stall, reset only clears valids
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < PIPE_DEPTH; i++) track_p[i].valid <= 1'b0;
    end else if (!stall) begin
      track_p[0] <= '{valid: if_valid, taken: pred_taken, target: btb_target};
      for (int i = 1; i < PIPE_DEPTH; i++) track_p[i] <= track_p[i-1];
    end
  end

  assign ex_trk = track_p[PIPE_DEPTH-1];

  // EX: compare tracked prediction with resolved outcome
  always_comb begin
    checked    = rst_n & ex_valid & ex_trk.valid;
    mispredict = 1'b0;
    if (checked) begin
      if (ex_is_branch) begin
        mispredict = (ex_taken != ex_trk.taken) |
                     (ex_taken & ex_trk.taken & (ex_target != ex_trk.target));
      end else begin
        mispredict = ex_trk.taken;
      end
    end
  end

  assign flush       = mispredict;
  assign redirect_pc = (ex_is_branch & ex_taken) ? ex_target : ex_pc + PC_INC;
  assign br_update   = checked & ex_is_branch & ex_taken & (ex_pc[1:0] == 2'b00) & ~stall;
  assign bht_wr_en   = checked & ex_is_branch & ~stall;
  assign pc_ex       = ex_pc;
  assign target_pc   = ex_target;

  // saturating performance counters, frozen while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (!stall) begin
      if (checked && ex_is_branch && !(&br_count)) br_count <= br_count + CNT_W'(1);
      if (mispredict && !(&mispred_count))       mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a behavioural predictor model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        if_valid;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_pc;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        br_update;
  logic [31:0] pc_ex;
  logic [31:0] target_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.BHT_IDX_W(8), .PIPE_DEPTH(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .if_valid(if_valid), .btb_hit(btb_hit),
    .btb_target(btb_target), .stall(stall), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pc(ex_pc), .next_pc(next_pc),
    .pred_taken(pred_taken), .flush(flush), .redirect_pc(redirect_pc), .br_update(br_update),
    .pc_ex(pc_ex), .target_pc(target_pc), .br_count(br_count), .mispred_count(mispred_count)
  );

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    bit          t;
    logic [31:0] tg;
  } ent_t;

  ent_t        mq[$];          // in-flight predictions, oldest (EX) at the back
  int          bht_m [256];
  logic [31:0] brc_m, mis_m;

  initial begin
    ent_t e0;
    e0.v = 0; e0.t = 0; e0.tg = '0;
    repeat (2) mq.push_back(e0);
    foreach (bht_m[i]) bht_m[i] = 1;
    brc_m = 0;
    mis_m = 0;
  end

  function automatic bit m_checked();
    return rst_n && ex_valid && mq[$].v;
  endfunction

  function automatic bit m_misp();
    if (!m_checked()) return 0;
    if (ex_is_branch)
      return (ex_taken != mq[$].t) || (ex_taken && mq[$].t && ex_target != mq[$].tg);
    return mq[$].t;
  endfunction

  function automatic bit m_pred();
    return if_valid && btb_hit && (bht_m[pc_in[9:2]] >= 2);
  endfunction

  always @(posedge clk) begin
    bit   chk, mp;
    ent_t e;
    int   idx;
    if (!rst_n) begin
      foreach (bht_m[i]) bht_m[i] = 1;
      foreach (mq[i]) mq[i].v = 0;
      brc_m = 0;
      mis_m = 0;
    end else begin
      chk  = m_checked();
      mp   = m_misp();
      e.v  = if_valid;
      e.t  = m_pred();
      e.tg = btb_target;
      if (chk && ex_is_branch && !stall) begin
        idx = int'(ex_pc[9:2]);
        if (ex_taken) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
        else          bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;
      end
      if (!stall && chk && ex_is_branch && brc_m != '1) brc_m = brc_m + 1;
      if (!stall && mp && mis_m != '1) mis_m = mis_m + 1;
      if (mp) begin
        foreach (mq[i]) mq[i].v = 0;
      end else if (!stall) begin
        mq.push_front(e);
        void'(mq.pop_back());
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit ep, emp;
    if (started) begin
      ep  = m_pred();
      emp = m_misp();
      lit("pred_taken", {31'b0, pred_taken}, {31'b0, ep});
      lit("next_pc", next_pc, ep ? btb_target : pc_in + 32'd4);
      lit("flush", {31'b0, flush}, {31'b0, emp});
      if (emp)
        lit("redirect_pc", redirect_pc, (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4);
      lit("br_update", {31'b0, br_update},
          {31'b0, m_checked() && ex_is_branch && ex_taken && ex_pc[1:0] == 2'b00 && !stall});
      lit("pc_ex", pc_ex, ex_pc);
      lit("target_pc", target_pc, ex_target);
      lit("br_count", br_count, brc_m);
      lit("mispred_count", mispred_count, mis_m);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 0; btb_hit = 0; stall = 0; ex_valid = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input bit hit, input logic [31:0] tgt);
    if_valid = 1; pc_in = pc; btb_hit = hit; btb_target = tgt;
  endtask

  task automatic exec(input bit br, input bit tk, input logic [31:0] tgt, input logic [31:0] pc);
    ex_valid = 1; ex_is_branch = br; ex_taken = tk; ex_target = tgt; ex_pc = pc;
  endtask

  // fetch one instruction, let it travel to EX, present the resolution, stop at negedge
  task automatic resolve(input logic [31:0] fpc, input bit fhit, input logic [31:0] ftgt,
                         input bit br, input bit tk, input logic [31:0] etgt,
                         input logic [31:0] epc);
    idle();
    fetch(fpc, fhit, ftgt);
    tick();
    if_valid = 0;
    tick();
    exec(br, tk, etgt, epc);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 0; pc_in = 0; btb_target = 0; ex_is_branch = 0; ex_taken = 0;
    ex_target = 0; ex_pc = 0;
    idle();
    tick();
    started = 1;
    tick();
    exec(1, 1, 32'h200, 32'h100);
    @(negedge clk);
    lit("rst_flush", {31'b0, flush}, 0);
    lit("rst_br_update", {31'b0, br_update}, 0);
    tick();

    // first fetch of 0x100: counter weakly not-taken
    rst_n = 1;
    idle();
    fetch(32'h100, 1, 32'h200);
    @(negedge clk);
    lit("first_pred", {31'b0, pred_taken}, 0);
    lit("first_next_pc", next_pc, 32'h104);
    tick();
    if_valid = 0;
    tick();
    exec(1, 1, 32'h200, 32'h100);
    @(negedge clk);
    lit("train1_flush", {31'b0, flush}, 1);
    lit("train1_redirect", redirect_pc, 32'h200);
    lit("train1_br_update", {31'b0, br_update}, 1);
    tick();

    // counter now 10: predicted taken, resolved identically
    idle();
    fetch(32'h100, 1, 32'h200);
    @(negedge clk);
    lit("trained_pred", {31'b0, pred_taken}, 1);
    lit("trained_next_pc", next_pc, 32'h200);
    tick();
    if_valid = 0;
    tick();
    exec(1, 1, 32'h200, 32'h100);
    @(negedge clk);
    lit("train2_flush", {31'b0, flush}, 0);
    lit("train2_br_update", {31'b0, br_update}, 1);
    tick();
    idle();
    @(negedge clk);
    lit("cnt_after_train_br", br_count, 2);
    lit("cnt_after_train_mis", mispred_count, 1);
    tick();

    // wrong target at a saturated counter
    resolve(32'h100, 1, 32'h200, 1, 1, 32'h300, 32'h100);
    lit("tgt_flush", {31'b0, flush}, 1);
    lit("tgt_redirect", redirect_pc, 32'h300);
    tick();
    idle();
    @(negedge clk);
    lit("tgt_mispred_count", mispred_count, 2);
    tick();

    // not-taken resolution: 11 -> 10, still predicts taken
    resolve(32'h100, 1, 32'h200, 1, 0, 32'h200, 32'h100);
    lit("nt_redirect", redirect_pc, 32'h104);
    tick();
    idle();
    fetch(32'h100, 1, 32'h200);
    @(negedge clk);
    lit("after_nt_pred", {31'b0, pred_taken}, 1);
    tick();
    idle();
    repeat (2) tick();

    // false hit on a non-branch at 0x40 (train index first)
    resolve(32'h40, 0, 32'h0, 1, 1, 32'h80, 32'h40);
    tick();
    idle();
    fetch(32'h40, 1, 32'h80);
    @(negedge clk);
    lit("fh_pred", {31'b0, pred_taken}, 1);
    tick();
    if_valid = 0;
    tick();
    exec(0, 0, 32'h0, 32'h40);
    @(negedge clk);
    lit("fh_flush", {31'b0, flush}, 1);
    lit("fh_redirect", redirect_pc, 32'h44);
    lit("fh_br_update", {31'b0, br_update}, 0);
    tick();
    idle();
    fetch(32'h40, 1, 32'h80);
    @(negedge clk);
    lit("fh_bht_kept", {31'b0, pred_taken}, 1);
    tick();
    idle();
    repeat (2) tick();

    // stall holds a correct prediction in EX for 3 cycles
    resolve(32'h100, 1, 32'h200, 1, 1, 32'h200, 32'h100);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit("stall_br_update", {31'b0, br_update}, 0);
      lit("stall_flush", {31'b0, flush}, 0);
      tick();
    end
    stall = 0;
    @(negedge clk);
    lit("release_br_update", {31'b0, br_update}, 1);
    tick();
    idle();
    @(negedge clk);
    lit("release_br_count", br_count, 6);
    lit("release_mispred_count", mispred_count, 5);
    tick();

    // flush while stalled clears both stages
    fetch(32'h100, 1, 32'h999);
    tick();
    fetch(32'h100, 1, 32'h200);
    tick();
    if_valid = 0;
    stall = 1;
    exec(1, 1, 32'h200, 32'h100);
    @(negedge clk);
    lit("sf_flush", {31'b0, flush}, 1);
    lit("sf_redirect", redirect_pc, 32'h200);
    tick();
    @(negedge clk);
    lit("sf_ex_cleared", {31'b0, flush}, 0);
    tick();
    stall = 0;
    ex_valid = 0;
    tick();
    exec(0, 0, 32'h0, 32'h100);
    @(negedge clk);
    lit("sf_id_cleared", {31'b0, flush}, 0);
    tick();
    idle();

    // counter saturates at 00
    resolve(32'h80, 0, 32'h0, 1, 0, 32'h0, 32'h80);
    tick();
    resolve(32'h80, 0, 32'h0, 1, 0, 32'h0, 32'h80);
    tick();
    resolve(32'h80, 0, 32'h0, 1, 1, 32'h300, 32'h80);
    tick();
    idle();
    fetch(32'h80, 1, 32'h300);
    @(negedge clk);
    lit("sat00_pred", {31'b0, pred_taken}, 0);
    lit("sat00_next_pc", next_pc, 32'h84);
    tick();

    // PC wrap
    fetch(32'hFFFF_FFFC, 0, 32'h0);
    @(negedge clk);
    lit("wrap_next_pc", next_pc, 32'h0);
    tick();
    idle();
    repeat (2) tick();

    // misaligned taken branch: no BTB write
    resolve(32'h102, 0, 32'h0, 1, 1, 32'h200, 32'h102);
    lit("misalign_br_update", {31'b0, br_update}, 0);
    lit("misalign_flush", {31'b0, flush}, 1);
    tick();
    idle();

    // reset mid-run drops pending check and clears state
    fetch(32'h100, 1, 32'h200);
    tick();
    fetch(32'h104, 0, 32'h0);
    tick();
    if_valid = 0;
    rst_n = 0;
    exec(1, 1, 32'h500, 32'h100);
    @(negedge clk);
    lit("midrst_flush", {31'b0, flush}, 0);
    lit("midrst_br_update", {31'b0, br_update}, 0);
    tick();
    rst_n = 1;
    @(negedge clk);
    lit("postrst_flush", {31'b0, flush}, 0);
    lit("postrst_br_count", br_count, 0);
    lit("postrst_mispred_count", mispred_count, 0);
    tick();
    idle();
    fetch(32'h100, 1, 32'h200);
    @(negedge clk);
    lit("postrst_pred", {31'b0, pred_taken}, 0);
    tick();
    idle();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
